// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage.
//
// Handshake: the stage holds mem_req high, with mem_we/mem_adr/mem_wdat
// stable, until the memory answers with mem_ack. Each cycle in which
// mem_req and mem_ack are both high completes exactly one access. For a
// read, mem_rdat is valid only in that cycle. mem_ack outside a request is
// ignored. An access may complete in the same cycle it is first requested.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [15:0] mem_wdat;
    logic [15:0] mem_rdat;
    logic        mem_ack;

    // Pipeline side: issues requests, consumes the acknowledge.
    modport master (
        output mem_req,
        output mem_we,
        output mem_adr,
        output mem_wdat,
        input  mem_rdat,
        input  mem_ack
    );

    // Memory side: serves requests.
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_adr,
        input  mem_wdat,
        output mem_rdat,
        output mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 16-bit pipelined core.
// Drives the data-memory request port and owns the MEM/WB register. It also
// selects write-back data, latches the OUT port and handles HALT. While an
// access is outstanding, stall_mem freezes EX/MEM and every upstream stage.
// A run-control FSM (RUN/WAIT/HALT/ERR) is exposed on state_dbg.
module mem_stage #(
    parameter int TIMEOUT = 255   // max WAIT cycles before ERR; 0 = never time out
) (
    input  logic               clk,
    input  logic               reset,

    // EX/MEM register outputs
    input  logic [15:0]        ALUres_mem,
    input  logic [15:0]        pcinc_mem,
    input  logic [15:0]        rd1_mem,
    input  logic [15:0]        extended_d_mem,
    input  logic [2:0]         regwrite_adr_mem,
    input  logic               main_mem_read,
    input  logic               main_mem_write,
    input  logic [1:0]         regwrite_dat_controll,
    input  logic               from_main_mem_mem,
    input  logic               regwrite_mem,
    input  logic               is_halt,
    input  logic               out_en,
    input  logic [15:0]        out_dat,

    // Data-memory port
    mem_stage_if.master        mem,

    // Hazard unit
    output logic               stall_mem,

    // MEM/WB register
    output logic               regwrite_wb,
    output logic [2:0]         regwrite_adr_wb,
    output logic [15:0]        regwrite_dat_wb,

    // OUT port and core status
    output logic [15:0]        out_port,
    output logic               out_strobe,
    output logic               halted,
    output logic               mem_err,

    // Run-control state: 0 RUN, 1 WAIT, 2 HALT, 3 ERR
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // The counter only needs to reach TIMEOUT. Keep at least one bit so
    // TIMEOUT = 0 or 1 still elaborates.
    localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          acc;        // instruction in MEM touches memory
    logic          req_c;      // request before reset gating
    logic          stall_c;    // stall before reset gating
    logic          adv;        // MEM/WB accepts the instruction this cycle

    logic          wb_q, wb_d;
    logic [2:0]    wb_adr_q, wb_adr_d;
    logic [15:0]   wb_dat_q, wb_dat_d;
    logic [15:0]   out_port_q, out_port_d;
    logic          out_strobe_q, out_strobe_d;

    assign acc = main_mem_read | main_mem_write;

    // Run-control FSM: next state, wait counter, request and stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        unique case (state_q)
            S_RUN: begin
                req_c   = acc;
                stall_c = acc & ~mem.mem_ack;
                if (acc && !mem.mem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (is_halt) begin
                    // Not stalled here, so the HALT instruction retires now.
                    state_d = S_HALT;
                end
            end
            S_WAIT: begin
                // EX/MEM is frozen, so address and data stay stable.
                req_c   = 1'b1;
                stall_c = ~mem.mem_ack;
                if (mem.mem_ack) begin
                    state_d = S_RUN;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_MAX)) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HALT: begin
                stall_c = 1'b1;
            end
            S_ERR: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Run-control state and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // HALT and ERR always stall, so adv is only ever high in RUN/WAIT.
    assign adv = ~stall_c;

    // MEM/WB next values: advance the instruction, or insert a bubble.
    always_comb begin
        wb_d     = 1'b0;
        wb_adr_d = wb_adr_q;
        wb_dat_d = wb_dat_q;
        if (adv) begin
            // HALT retires without writing a register.
            wb_d     = regwrite_mem & ~is_halt;
            wb_adr_d = regwrite_adr_mem;
            if (from_main_mem_mem) begin
                wb_dat_d = mem.mem_rdat;
            end else begin
                unique case (regwrite_dat_controll)
                    2'b01:   wb_dat_d = pcinc_mem;
                    2'b10:   wb_dat_d = extended_d_mem;
                    default: wb_dat_d = ALUres_mem;
                endcase
            end
        end
    end

    // OUT port next values: latch on an advancing OUT instruction.
    always_comb begin
        out_port_d   = out_port_q;
        out_strobe_d = adv & out_en;
        if (adv && out_en) begin
            out_port_d = out_dat;
        end
    end

    // MEM/WB register and OUT latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q         <= 1'b0;
            wb_adr_q     <= 3'd0;
            wb_dat_q     <= 16'd0;
            out_port_q   <= 16'd0;
            out_strobe_q <= 1'b0;
        end else begin
            wb_q         <= wb_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_q     <= wb_dat_d;
            out_port_q   <= out_port_d;
            out_strobe_q <= out_strobe_d;
        end
    end

    // Reset also masks the combinational request and stall. This drops
    // mem_req immediately on a mid-access reset and abandons the access.
    assign mem.mem_req  = req_c & ~reset;
    assign mem.mem_we   = req_c & ~reset & main_mem_write;
    assign mem.mem_adr  = ALUres_mem;
    assign mem.mem_wdat = rd1_mem;
    assign stall_mem    = stall_c & ~reset;

    assign regwrite_wb     = wb_q;
    assign regwrite_adr_wb = wb_adr_q;
    assign regwrite_dat_wb = wb_dat_q;
    assign out_port        = out_port_q;
    assign out_strobe      = out_strobe_q;
    assign halted          = (state_q == S_HALT);
    assign mem_err         = (state_q == S_ERR);
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage built with TIMEOUT = 4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled away
// from the edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ALUres_mem, pcinc_mem, rd1_mem, extended_d_mem, out_dat;
    logic [2:0]  regwrite_adr_mem;
    logic        main_mem_read, main_mem_write, from_main_mem_mem;
    logic [1:0]  regwrite_dat_controll;
    logic        regwrite_mem, is_halt, out_en;
    logic        stall_mem, regwrite_wb, out_strobe, halted, mem_err;
    logic [2:0]  regwrite_adr_wb;
    logic [15:0] regwrite_dat_wb, out_port;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    mem_stage_if mif();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ALUres_mem            (ALUres_mem),
        .pcinc_mem             (pcinc_mem),
        .rd1_mem               (rd1_mem),
        .extended_d_mem        (extended_d_mem),
        .regwrite_adr_mem      (regwrite_adr_mem),
        .main_mem_read         (main_mem_read),
        .main_mem_write        (main_mem_write),
        .regwrite_dat_controll (regwrite_dat_controll),
        .from_main_mem_mem     (from_main_mem_mem),
        .regwrite_mem          (regwrite_mem),
        .is_halt               (is_halt),
        .out_en                (out_en),
        .out_dat               (out_dat),
        .mem                   (mif),
        .stall_mem             (stall_mem),
        .regwrite_wb           (regwrite_wb),
        .regwrite_adr_wb       (regwrite_adr_wb),
        .regwrite_dat_wb       (regwrite_dat_wb),
        .out_port              (out_port),
        .out_strobe            (out_strobe),
        .halted                (halted),
        .mem_err               (mem_err),
        .state_dbg             (state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ALUres_mem            = 16'h0000;
        pcinc_mem             = 16'h0000;
        rd1_mem               = 16'h0000;
        extended_d_mem        = 16'h0000;
        regwrite_adr_mem      = 3'd0;
        main_mem_read         = 1'b0;
        main_mem_write        = 1'b0;
        regwrite_dat_controll = 2'b00;
        from_main_mem_mem     = 1'b0;
        regwrite_mem          = 1'b0;
        is_halt               = 1'b0;
        out_en                = 1'b0;
        out_dat               = 16'h0000;
        mif.mem_rdat          = 16'h0000;
        mif.mem_ack           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset state
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        checks++; if (regwrite_wb !== 1'b0) begin failures++; $display("FAIL reset_regwrite_wb got=%b exp=0", regwrite_wb); end
        checks++; if (regwrite_dat_wb !== 16'h0000) begin failures++; $display("FAIL reset_dat got=%h exp=0000", regwrite_dat_wb); end
        checks++; if (regwrite_adr_wb !== 3'd0) begin failures++; $display("FAIL reset_adr got=%0d exp=0", regwrite_adr_wb); end
        checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mif.mem_req); end
        checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_mem); end
        checks++; if ({halted, mem_err, out_strobe} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {halted, mem_err, out_strobe}); end
        checks++; if (out_port !== 16'h0000) begin failures++; $display("FAIL reset_out_port got=%h exp=0000", out_port); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Write-back source selection with no memory access
    task automatic test_alu();
        logic [15:0] exp_dat [4];
        exp_dat[0] = 16'h1234;   // 00 ALU
        exp_dat[1] = 16'h0011;   // 01 pcinc
        exp_dat[2] = 16'hFFF0;   // 10 ext
        exp_dat[3] = 16'h1234;   // 11 ALU
        ALUres_mem     = 16'h1234;
        pcinc_mem      = 16'h0011;
        extended_d_mem = 16'hFFF0;
        regwrite_mem   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            regwrite_dat_controll = 2'(i);
            regwrite_adr_mem      = 3'(i + 3);
            #1;
            checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL alu_stall[%0d] got=%b exp=0", i, stall_mem); end
            checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL alu_req[%0d] got=%b exp=0", i, mif.mem_req); end
            tick();
            checks++; if (regwrite_wb !== 1'b1) begin failures++; $display("FAIL alu_wb[%0d] got=%b exp=1", i, regwrite_wb); end
            checks++; if (regwrite_adr_wb !== 3'(i + 3)) begin failures++; $display("FAIL alu_adr[%0d] got=%0d exp=%0d", i, regwrite_adr_wb, i + 3); end
            checks++; if (regwrite_dat_wb !== exp_dat[i]) begin failures++; $display("FAIL alu_dat[%0d] got=%h exp=%h", i, regwrite_dat_wb, exp_dat[i]); end
        end
        idle_inputs();
        tick();
    endtask

    // Load acknowledged three cycles after the request
    task automatic test_load();
        int stall_cnt = 0;
        main_mem_read     = 1'b1;
        ALUres_mem        = 16'h0040;
        from_main_mem_mem = 1'b1;
        regwrite_mem      = 1'b1;
        regwrite_adr_mem  = 3'd5;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                mif.mem_ack  = 1'b1;
                mif.mem_rdat = 16'hBEEF;
            end
            #1;
            if (stall_mem === 1'b1) stall_cnt++;
            checks++; if (mif.mem_req !== 1'b1) begin failures++; $display("FAIL load_req[%0d] got=%b exp=1", k, mif.mem_req); end
            checks++; if (mif.mem_we !== 1'b0) begin failures++; $display("FAIL load_we[%0d] got=%b exp=0", k, mif.mem_we); end
            checks++; if (mif.mem_adr !== 16'h0040) begin failures++; $display("FAIL load_adr[%0d] got=%h exp=0040", k, mif.mem_adr); end
            if (k > 0) begin
                checks++; if (regwrite_wb !== 1'b0) begin failures++; $display("FAIL load_bubble[%0d] got=%b exp=0", k, regwrite_wb); end
                checks++; if (state_dbg !== 2'd1) begin failures++; $display("FAIL load_state[%0d] got=%0d exp=1", k, state_dbg); end
            end
            tick();
        end
        checks++; if (stall_cnt !== 3) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=3", stall_cnt); end
        checks++; if (regwrite_wb !== 1'b1) begin failures++; $display("FAIL load_wb got=%b exp=1", regwrite_wb); end
        checks++; if (regwrite_adr_wb !== 3'd5) begin failures++; $display("FAIL load_wb_adr got=%0d exp=5", regwrite_adr_wb); end
        checks++; if (regwrite_dat_wb !== 16'hBEEF) begin failures++; $display("FAIL load_dat got=%h exp=BEEF", regwrite_dat_wb); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL load_back_run got=%0d exp=0", state_dbg); end
        idle_inputs();
        tick();
    endtask

    // Single-cycle stores, including read+write treated as a write
    task automatic test_store();
        for (int v = 0; v < 2; v++) begin
            main_mem_write = 1'b1;
            main_mem_read  = (v == 1);
            rd1_mem        = (v == 0) ? 16'h00A5 : 16'h5A00;
            ALUres_mem     = 16'h0100;
            regwrite_mem   = 1'b0;
            mif.mem_ack    = 1'b1;
            #1;
            checks++; if (mif.mem_req !== 1'b1) begin failures++; $display("FAIL store_req[%0d] got=%b exp=1", v, mif.mem_req); end
            checks++; if (mif.mem_we !== 1'b1) begin failures++; $display("FAIL store_we[%0d] got=%b exp=1", v, mif.mem_we); end
            checks++; if (mif.mem_wdat !== ((v == 0) ? 16'h00A5 : 16'h5A00)) begin failures++; $display("FAIL store_wdat[%0d] got=%h", v, mif.mem_wdat); end
            checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL store_stall[%0d] got=%b exp=0", v, stall_mem); end
            tick();
            checks++; if (regwrite_wb !== 1'b0) begin failures++; $display("FAIL store_wb[%0d] got=%b exp=0", v, regwrite_wb); end
            checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL store_state[%0d] got=%0d exp=0", v, state_dbg); end
        end
        idle_inputs();
        tick();
    endtask

    // OUT followed by HALT
    task automatic test_out_halt();
        out_en  = 1'b1;
        out_dat = 16'h0042;
        tick();
        checks++; if (out_port !== 16'h0042) begin failures++; $display("FAIL out_port got=%h exp=0042", out_port); end
        checks++; if (out_strobe !== 1'b1) begin failures++; $display("FAIL out_strobe got=%b exp=1", out_strobe); end
        out_en           = 1'b0;
        is_halt          = 1'b1;
        regwrite_mem     = 1'b1;
        regwrite_adr_mem = 3'd7;
        #1;
        checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL halt_issue_stall got=%b exp=0", stall_mem); end
        tick();
        checks++; if (out_strobe !== 1'b0) begin failures++; $display("FAIL out_strobe_pulse got=%b exp=0", out_strobe); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halted got=%b exp=1", halted); end
        checks++; if (regwrite_wb !== 1'b0) begin failures++; $display("FAIL halt_own_wb got=%b exp=0", regwrite_wb); end
        checks++; if (state_dbg !== 2'd2) begin failures++; $display("FAIL halt_state got=%0d exp=2", state_dbg); end
        is_halt    = 1'b0;
        out_en     = 1'b1;
        out_dat    = 16'h0099;
        ALUres_mem = 16'h7777;
        for (int j = 0; j < 2; j++) begin
            tick();
            checks++; if (regwrite_wb !== 1'b0) begin failures++; $display("FAIL after_halt_wb[%0d] got=%b exp=0", j, regwrite_wb); end
            checks++; if (stall_mem !== 1'b1) begin failures++; $display("FAIL after_halt_stall[%0d] got=%b exp=1", j, stall_mem); end
            checks++; if (out_port !== 16'h0042 || out_strobe !== 1'b0) begin failures++; $display("FAIL after_halt_out[%0d] got=%h/%b exp=0042/0", j, out_port, out_strobe); end
            checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL after_halt_req[%0d] got=%b exp=0", j, mif.mem_req); end
        end
        idle_inputs();
    endtask

    // Memory never acknowledges: ERR after 4 WAIT cycles
    task automatic test_timeout();
        do_reset();
        main_mem_read = 1'b1;
        ALUres_mem    = 16'h0300;
        for (int t = 1; t <= 5; t++) begin
            tick();
            if (t < 5) begin
                checks++; if (state_dbg !== 2'd1 || mem_err !== 1'b0) begin failures++; $display("FAIL timeout_wait[%0d] state=%0d err=%b exp=1/0", t, state_dbg, mem_err); end
                checks++; if (mif.mem_req !== 1'b1) begin failures++; $display("FAIL timeout_req[%0d] got=%b exp=1", t, mif.mem_req); end
            end else begin
                checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", mem_err); end
                checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL timeout_req_drop got=%b exp=0", mif.mem_req); end
                checks++; if (state_dbg !== 2'd3) begin failures++; $display("FAIL timeout_state got=%0d exp=3", state_dbg); end
            end
        end
        mif.mem_ack = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (stall_mem !== 1'b1 || mem_err !== 1'b1) begin failures++; $display("FAIL err_sticky[%0d] stall=%b err=%b exp=1/1", j, stall_mem, mem_err); end
        end
        do_reset();
        checks++; if (mem_err !== 1'b0 || stall_mem !== 1'b0) begin failures++; $display("FAIL err_cleared err=%b stall=%b exp=0/0", mem_err, stall_mem); end
    endtask

    // Asynchronous reset in the middle of a WAIT, then a normal load
    task automatic test_reset_mid_wait();
        do_reset();
        main_mem_read     = 1'b1;
        ALUres_mem        = 16'h0200;
        from_main_mem_mem = 1'b1;
        regwrite_mem      = 1'b1;
        regwrite_adr_mem  = 3'd2;
        tick();
        tick();
        checks++; if (state_dbg !== 2'd1) begin failures++; $display("FAIL midwait_pre_state got=%0d exp=1", state_dbg); end
        #3 reset = 1'b1;
        #1;
        checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL midwait_req got=%b exp=0", mif.mem_req); end
        checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL midwait_stall got=%b exp=0", stall_mem); end
        checks++; if ({regwrite_wb, halted, mem_err, out_strobe} !== 4'b0000) begin failures++; $display("FAIL midwait_regs got=%b exp=0000", {regwrite_wb, halted, mem_err, out_strobe}); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL midwait_state got=%0d exp=0", state_dbg); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mif.mem_req !== 1'b1 || stall_mem !== 1'b1) begin failures++; $display("FAIL midwait_rerequest req=%b stall=%b exp=1/1", mif.mem_req, stall_mem); end
        tick();
        mif.mem_ack  = 1'b1;
        mif.mem_rdat = 16'hCAFE;
        #1;
        checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL midwait_ack_stall got=%b exp=0", stall_mem); end
        tick();
        checks++; if (regwrite_wb !== 1'b1 || regwrite_adr_wb !== 3'd2) begin failures++; $display("FAIL midwait_wb got=%b/%0d exp=1/2", regwrite_wb, regwrite_adr_wb); end
        checks++; if (regwrite_dat_wb !== 16'hCAFE) begin failures++; $display("FAIL midwait_dat got=%h exp=CAFE", regwrite_dat_wb); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_out_halt();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
